// File: rtl/reg_trace_streamer_if.sv
// Beat stream from the trace streamer to its sink: one header beat, then one beat per register.
interface reg_trace_streamer_if #(
    parameter int DATA_W = 32,
    parameter int CYC_W  = 32,
    parameter int IW     = 5
);
    logic              o_valid;
    logic              i_ready;
    logic              o_hdr;
    logic [IW-1:0]     o_idx;
    logic [DATA_W-1:0] o_data;
    logic [CYC_W-1:0]  o_cycle;
    logic              o_last;

    modport master (
        output o_valid, o_hdr, o_idx, o_data, o_cycle, o_last,
        input  i_ready
    );

    modport slave (
        input  o_valid, o_hdr, o_idx, o_data, o_cycle, o_last,
        output i_ready
    );
endinterface

// File: rtl/reg_trace_streamer.sv
// Register-file snapshot streamer: on a trigger, emits a PC/cycle header followed by
// every register-file entry, read one at a time through a single read port.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for an effective trigger (i_trig or auto period)
// HDR    | header beat presented (PC + captured cycle)
// RD     | read address driven for idx, data captured at exit
// BEAT   | register beat presented for idx
module reg_trace_streamer #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32,
    parameter int CYC_W    = 32,
    parameter int PERIOD   = 0
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_trig,
    input  logic [DATA_W-1:0]           i_pc,
    output logic [$clog2(NUM_REGS)-1:0] o_rd_addr,
    input  logic [DATA_W-1:0]           i_rd_data,
    output logic                        o_busy,
    output logic [7:0]                  o_drops,
    reg_trace_streamer_if.master        tr
);
    localparam int IW = $clog2(NUM_REGS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_RD,
        S_BEAT
    } state_t;

    state_t            state_q, state_d;
    logic [CYC_W-1:0]  cnt_q, cnt_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [IW-1:0]     rd_addr_q, rd_addr_d;
    logic [7:0]        drops_q, drops_d;
    logic              auto_trig;
    logic              trig;
    logic              is_last;
    logic              drop;

    // Modulo is taken in a widened domain so any PERIOD value compares correctly.
    generate
        if (PERIOD == 0) begin : g_no_auto
            assign auto_trig = 1'b0;
        end else begin : g_auto
            localparam int MW = CYC_W + 32;
            localparam int unsigned PMOD = PERIOD;
            logic [MW-1:0] cnt_ext;
            assign cnt_ext   = {32'd0, cnt_q};
            assign auto_trig = ((cnt_ext % MW'(PMOD)) == MW'(PMOD - 1));
        end
    endgenerate

    assign trig    = i_trig | auto_trig;
    assign is_last = (idx_q == IW'(NUM_REGS - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CYC_W'(1);
        cyc_d     = cyc_q;
        pc_d      = pc_q;
        data_d    = data_q;
        idx_d     = idx_q;
        rd_addr_d = rd_addr_q;
        drop      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (trig) begin
                    cyc_d   = cnt_q;
                    pc_d    = i_pc;
                    idx_d   = '0;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                drop = trig;
                if (tr.i_ready) begin
                    state_d = S_RD;
                end
            end
            S_RD: begin
                drop      = trig;
                rd_addr_d = idx_q;
                data_d    = i_rd_data;
                state_d   = S_BEAT;
            end
            S_BEAT: begin
                drop = trig;
                if (tr.i_ready) begin
                    if (is_last) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = S_RD;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        drops_d = (drop && (drops_q != 8'hFF)) ? drops_q + 8'd1 : drops_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            cyc_q     <= '0;
            pc_q      <= '0;
            data_q    <= '0;
            idx_q     <= '0;
            rd_addr_q <= '0;
            drops_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cyc_q     <= cyc_d;
            pc_q      <= pc_d;
            data_q    <= data_d;
            idx_q     <= idx_d;
            rd_addr_q <= rd_addr_d;
            drops_q   <= drops_d;
        end
    end

    // Beat fields come straight from captured registers, so they hold while stalled.
    always_comb begin
        o_rd_addr  = (state_q == S_RD) ? idx_q : rd_addr_q;
        o_busy     = (state_q != S_IDLE);
        o_drops    = drops_q;
        tr.o_valid = (state_q == S_HDR) || (state_q == S_BEAT);
        tr.o_hdr   = (state_q == S_HDR);
        tr.o_idx   = (state_q == S_BEAT) ? idx_q : '0;
        tr.o_data  = (state_q == S_HDR) ? pc_q : data_q;
        tr.o_cycle = cyc_q;
        tr.o_last  = (state_q == S_BEAT) && is_last;
    end
endmodule

// File: tb/tb_reg_trace_streamer.sv
// Bench for reg_trace_streamer: scoreboarded snapshots on a 32-entry instance, plus
// an auto-period instance and a narrow-counter instance.
module tb_reg_trace_streamer;
    localparam int N0 = 32;
    localparam int N1 = 4;
    localparam int N2 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic rst2;

    // main instance
    logic        trig0;
    logic [31:0] pc0;
    logic [4:0]  rda0;
    logic [31:0] rdd0;
    logic        busy0;
    logic [7:0]  drops0;
    logic [31:0] rf0 [N0];
    reg_trace_streamer_if #(.DATA_W(32), .CYC_W(32), .IW(5)) tf0 ();
    assign rdd0 = rf0[rda0];

    reg_trace_streamer #(.NUM_REGS(N0), .DATA_W(32), .CYC_W(32), .PERIOD(0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_trig(trig0), .i_pc(pc0), .o_rd_addr(rda0),
        .i_rd_data(rdd0), .o_busy(busy0), .o_drops(drops0), .tr(tf0)
    );

    // auto-period instance
    logic        trig1;
    logic [31:0] pc1;
    logic [1:0]  rda1;
    logic [31:0] rdd1;
    logic        busy1;
    logic [7:0]  drops1;
    reg_trace_streamer_if #(.DATA_W(32), .CYC_W(32), .IW(2)) tf1 ();
    assign rdd1 = 32'hA0 + {30'd0, rda1};

    reg_trace_streamer #(.NUM_REGS(N1), .DATA_W(32), .CYC_W(32), .PERIOD(100)) dut1 (
        .i_clk(clk), .i_rst(rst2), .i_trig(trig1), .i_pc(pc1), .o_rd_addr(rda1),
        .i_rd_data(rdd1), .o_busy(busy1), .o_drops(drops1), .tr(tf1)
    );

    // narrow-counter instance
    logic        trig2;
    logic [31:0] pc2;
    logic        rda2;
    logic [31:0] rdd2;
    logic        busy2;
    logic [7:0]  drops2;
    reg_trace_streamer_if #(.DATA_W(32), .CYC_W(4), .IW(1)) tf2 ();
    assign rdd2 = {31'd0, rda2};

    reg_trace_streamer #(.NUM_REGS(N2), .DATA_W(32), .CYC_W(4), .PERIOD(0)) dut2 (
        .i_clk(clk), .i_rst(rst2), .i_trig(trig2), .i_pc(pc2), .o_rd_addr(rda2),
        .i_rd_data(rdd2), .o_busy(busy2), .o_drops(drops2), .tr(tf2)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // cycle-counter models (counter value visible during the current cycle)
    logic [31:0] tb_cyc = '0;
    logic [31:0] tb_cyc2 = '0;
    always @(posedge clk) tb_cyc  <= rst  ? tb_cyc + 32'd1  : 32'd0;
    always @(posedge clk) tb_cyc2 <= rst2 ? tb_cyc2 + 32'd1 : 32'd0;

    // sink ready pattern: 0 always, 1 toggle, 2 random, other held low
    int   rdy_mode = 3;
    logic tgl = 1'b0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: tf0.i_ready = 1'b1;
            1: begin tgl = ~tgl; tf0.i_ready = tgl; end
            2: tf0.i_ready = 1'($urandom_range(0, 1));
            default: tf0.i_ready = 1'b0;
        endcase
    end

    typedef struct {
        logic       hdr;
        logic [4:0] idx;
        logic [31:0] data;
        logic [31:0] cyc;
        logic       last;
    } beat_t;
    beat_t sbq[$];

    task automatic push_snap(input logic [31:0] pc, input logic [31:0] cyc);
        beat_t b;
        b.hdr = 1'b1; b.idx = '0; b.data = pc; b.cyc = cyc; b.last = 1'b0;
        sbq.push_back(b);
        for (int k = 0; k < N0; k++) begin
            b.hdr  = 1'b0;
            b.idx  = 5'(k);
            b.data = rf0[k];
            b.last = (k == N0 - 1);
            sbq.push_back(b);
        end
    endtask

    int          busy_cnt = 0;
    logic        stalled = 1'b0;
    logic [70:0] held;
    always @(negedge clk) begin
        logic [70:0] cur;
        beat_t       e;
        cur = {tf0.o_hdr, tf0.o_idx, tf0.o_data, tf0.o_cycle, tf0.o_last};
        if (!rst) begin
            stalled = 1'b0;
        end else begin
            if (busy0) busy_cnt++;
            if (stalled && tf0.o_valid) chk("stall_hold", 128'(cur), 128'(held));
            if (tf0.o_valid && tf0.i_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_beat", 128'(cur), 128'hx);
                end else begin
                    e = sbq.pop_front();
                    chk("beat", 128'(cur), 128'({e.hdr, e.idx, e.data, e.cyc, e.last}));
                end
            end
            stalled = tf0.o_valid && !tf0.i_ready;
            held    = cur;
        end
    end

    int hdr1_cyc[$];
    always @(negedge clk) begin
        if (rst2 && tf1.o_valid && tf1.i_ready && tf1.o_hdr) begin
            hdr1_cyc.push_back(int'(tf1.o_cycle));
            chk("auto_hdr_pc", 128'(tf1.o_data), 128'(32'h55));
        end
    end

    int hdr2_cyc[$];
    always @(negedge clk) begin
        if (rst2 && tf2.o_valid && tf2.i_ready && tf2.o_hdr) hdr2_cyc.push_back(int'(tf2.o_cycle));
    end

    // narrow-counter stimulus: trigger at counter 15, then after the wrap at 37 (= 5 mod 16)
    initial begin
        trig2 = 1'b0;
        pc2   = 32'h22;
        for (int k = 0; k < 200 && tb_cyc2 != 32'd15; k++) begin @(posedge clk); #1; end
        trig2 = 1'b1;
        @(posedge clk); #1;
        trig2 = 1'b0;
        for (int k = 0; k < 200 && tb_cyc2 != 32'd37; k++) begin @(posedge clk); #1; end
        trig2 = 1'b1;
        @(posedge clk); #1;
        trig2 = 1'b0;
    end

    typedef struct {
        logic [31:0] pc;
        int          mode;
        int          n_drop;
        int          exp_drops;
    } vec_t;
    vec_t tbl[4];

    task automatic wait_done();
        for (int k = 0; k < 3000 && (sbq.size() != 0 || busy0); k++) begin @(posedge clk); #1; end
        chk("snap_done", 128'({sbq.size() != 0, busy0}), 128'(0));
    endtask

    initial begin
        tbl[0] = '{32'h80,       0, 0, 0};
        tbl[1] = '{32'h1234,     1, 0, 0};
        tbl[2] = '{32'hDEADBEEF, 2, 3, 3};
        tbl[3] = '{32'h4,        0, 2, 5};

        rst = 1'b0; rst2 = 1'b0;
        trig0 = 1'b0; pc0 = '0;
        trig1 = 1'b0; pc1 = 32'h55;
        tf1.i_ready = 1'b1;
        tf2.i_ready = 1'b1;
        for (int k = 0; k < N0; k++) rf0[k] = 32'(k * 32'h11);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 128'(tf0.o_valid), 128'(0));
        chk("rst_hdr",   128'(tf0.o_hdr),   128'(0));
        chk("rst_last",  128'(tf0.o_last),  128'(0));
        chk("rst_busy",  128'(busy0),       128'(0));
        chk("rst_idx",   128'(tf0.o_idx),   128'(0));
        chk("rst_data",  128'(tf0.o_data),  128'(0));
        chk("rst_cycle", 128'(tf0.o_cycle), 128'(0));
        chk("rst_drops", 128'(drops0),      128'(0));
        rst = 1'b1; rst2 = 1'b1;

        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                for (int k = 0; k < 100 && tb_cyc != 32'd5; k++) begin @(posedge clk); #1; end
            end else begin
                for (int k = 0; k < N0; k++) rf0[k] = $urandom;
                @(posedge clk); #1;
            end
            rdy_mode = tbl[i].mode;
            push_snap(tbl[i].pc, (i == 0) ? 32'd5 : tb_cyc);
            trig0 = 1'b1; pc0 = tbl[i].pc; busy_cnt = 0;
            @(posedge clk); #1;
            trig0 = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            for (int d = 0; d < tbl[i].n_drop; d++) begin
                trig0 = 1'b1;
                @(posedge clk); #1;
                trig0 = 1'b0;
                @(posedge clk); #1;
            end
            wait_done();
            if (tbl[i].mode == 0) chk("busy_cycles", 128'(busy_cnt), 128'(1 + 2 * N0));
            chk("drops", 128'(drops0), 128'(tbl[i].exp_drops));
        end

        repeat (10) @(posedge clk);
        #1;
        chk("no_extra_snap", 128'(busy0), 128'(0));

        // stalled header with the trigger held: drop counter must saturate
        rdy_mode = 3;
        pc0 = 32'h777;
        push_snap(pc0, tb_cyc);
        trig0 = 1'b1;
        @(posedge clk); #1;
        repeat (300) @(posedge clk);
        #1;
        trig0 = 1'b0;
        chk("drops_sat", 128'(drops0), 128'(255));
        rdy_mode = 0;
        wait_done();

        // reset while streaming register 10
        for (int k = 0; k < N0; k++) rf0[k] = $urandom;
        @(posedge clk); #1;
        pc0 = 32'h9000;
        push_snap(pc0, tb_cyc);
        trig0 = 1'b1;
        @(posedge clk); #1;
        trig0 = 1'b0;
        for (int k = 0; k < 200 && !(tf0.o_valid && !tf0.o_hdr && tf0.o_idx == 5'd10); k++) begin
            @(posedge clk); #1;
        end
        chk("reach_idx10", 128'({tf0.o_valid, tf0.o_hdr, tf0.o_idx}), 128'({1'b1, 1'b0, 5'd10}));
        rst = 1'b0;
        trig0 = 1'b1;
        sbq.delete();
        @(posedge clk); #1;
        chk("abort_valid", 128'(tf0.o_valid), 128'(0));
        chk("abort_busy",  128'(busy0),       128'(0));
        chk("abort_drops", 128'(drops0),      128'(0));
        @(posedge clk); #1;
        chk("rst_trig_ignored", 128'({busy0, drops0}), 128'(0));
        rst = 1'b1;
        trig0 = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rdy_mode = 0;
        pc0 = 32'hABC;
        push_snap(pc0, 32'd7);
        trig0 = 1'b1;
        @(posedge clk); #1;
        trig0 = 1'b0;
        wait_done();
        chk("drops_after_rst", 128'(drops0), 128'(0));

        // auto-period and narrow-counter results
        for (int k = 0; k < 1000 && tb_cyc2 < 32'd320; k++) begin @(posedge clk); #1; end
        chk("auto_n", 128'(hdr1_cyc.size() >= 3), 128'(1));
        for (int k = 0; k < 3; k++) begin
            chk("auto_cycle", (k < hdr1_cyc.size()) ? 128'(hdr1_cyc[k]) : 128'hx, 128'(99 + 100 * k));
        end
        chk("auto_drops", 128'(drops1), 128'(0));
        chk("wrap_n", 128'(hdr2_cyc.size()), 128'(2));
        chk("wrap_cycle15", (hdr2_cyc.size() > 0) ? 128'(hdr2_cyc[0]) : 128'hx, 128'(15));
        chk("wrap_cycle5",  (hdr2_cyc.size() > 1) ? 128'(hdr2_cyc[1]) : 128'hx, 128'(5));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/reg_trace_streamer.md
REG_TRACE_STREAMER -- requirements
Module: reg_trace_streamer

Interface
REQ-001 The parameter NUM_REGS SHALL default to 32 and set the number of register-file entries per snapshot (range 2..256).
REQ-002 The parameter DATA_W SHALL default to 32 and set the register and PC width.
REQ-003 The parameter CYC_W SHALL default to 32 and set the cycle-counter width.
REQ-004 The parameter PERIOD SHALL default to 0 and set the auto-snapshot interval in cycles; 0 disables auto snapshots.
REQ-005 The block SHALL have one clock and a synchronous, active-low reset, with ports as follows.
REQ-006 i_clk  in  1  clock; all state updates on the rising edge.
REQ-007 i_rst  in  1  synchronous active-low reset.
REQ-008 i_trig  in  1  request a snapshot this cycle.
REQ-009 i_pc  in  DATA_W  execute-stage PC, sampled at snapshot start.
REQ-010 o_rd_addr  out  IW=$clog2(NUM_REGS)  register-file read address.
REQ-011 i_rd_data  in  DATA_W  read data, valid one cycle after o_rd_addr changes.
REQ-012 o_valid  out  1  output beat valid.
REQ-013 i_ready  in  1  sink accepts beat.
REQ-014 o_hdr  out  1  beat is a header (1) or register beat (0).
REQ-015 o_idx  out  IW  register index of the beat (0 on header).
REQ-016 o_data  out  DATA_W  PC on header beat, register value otherwise.
REQ-017 o_cycle  out  CYC_W  cycle count captured at snapshot start, same for all beats of a snapshot.
REQ-018 o_last  out  1  final register beat of the snapshot.
REQ-019 o_busy  out  1  snapshot in progress.
REQ-020 o_drops  out  8  saturating count of discarded triggers.

Function
REQ-021 The cycle counter SHALL increment by 1 every cycle while not in reset and wrap from 2^CYC_W-1 to 0.
REQ-022 An auto trigger SHALL fire when PERIOD!=0 and counter mod PERIOD == PERIOD-1; the effective trigger SHALL be i_trig OR the auto trigger.
REQ-023 The FSM SHALL have the states IDLE, HDR, RD, BEAT.
REQ-024 In IDLE with an effective trigger, the block SHALL capture the counter and i_pc, set idx=0, and enter HDR on the next edge.
REQ-025 In HDR, o_valid=1 and o_hdr=1 SHALL hold; on o_valid&&i_ready the block SHALL enter RD.
REQ-026 In RD, o_rd_addr=idx and o_valid=0 SHALL hold for exactly one cycle, then the block SHALL enter BEAT.
REQ-027 In BEAT, the block SHALL present i_rd_data registered at the RD-to-BEAT edge, o_idx=idx, and o_last=(idx==NUM_REGS-1).
REQ-028 On BEAT acceptance, the block SHALL go to IDLE if o_last, else increment idx and go to RD.
REQ-029 While o_valid=1 and i_ready=0, o_hdr, o_idx, o_data, o_cycle and o_last SHALL be held stable.
REQ-030 o_rd_addr SHALL hold its last value outside RD.
REQ-031 An effective trigger outside IDLE, or in the final accepting BEAT cycle, SHALL be discarded and increment o_drops, saturating at 255.
REQ-032 o_busy SHALL be 1 in every state except IDLE.
REQ-033 The minimum snapshot length with i_ready held at 1 SHALL be 1+2*NUM_REGS cycles from HDR entry to return to IDLE.

Reset
REQ-034 While i_rst=0 at an edge, the block SHALL set the FSM to IDLE and clear the counter, idx, o_rd_addr, captured cycle/PC, data register and o_drops.
REQ-035 Reset values SHALL be: o_valid=0, o_hdr=0, o_last=0, o_busy=0, o_idx=0, o_data=0, o_cycle=0, o_drops=0.
REQ-036 Reset asserted mid-snapshot SHALL abort it with no further beats; triggers during reset SHALL be ignored and not counted.

Verification
REQ-037 Scenario: NUM_REGS=32, i_ready=1, regfile[i]=i*0x11, i_trig pulsed at counter=5, i_pc=0x80 -> header (o_data=0x80, o_cycle=5), then 32 beats idx 0..31 with values i*0x11, o_last only on idx 31, o_busy=1 for 65 cycles.
REQ-038 Scenario: i_ready toggled 0/1 every cycle during a snapshot -> each beat held stable while stalled, no beat lost or duplicated, all 33 beats delivered in order.
REQ-039 Scenario: PERIOD=100, i_ready=1, no i_trig -> snapshots start with captured o_cycle=99, 199, 299; o_drops stays 0.
REQ-040 Scenario: i_trig pulsed 3 times during a busy snapshot -> o_drops=3 and no extra snapshot; 300 dropped triggers -> o_drops=255.
REQ-041 Scenario: reset asserted at idx=10 -> next cycle o_valid=0, o_busy=0, o_drops=0, and a new i_trig produces a fresh header with o_cycle equal to cycles elapsed since reset release.
REQ-042 Scenario: CYC_W=4 with a trigger when the counter is 15 -> o_cycle=15, and the counter wraps to 0 on the next cycle.
